// File: rtl/arm_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states,
// condition codes, data-processing commands and datapath mux selects.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_e;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Raw per-state controls before condition gating.
  typedef struct packed {
    logic       next_pc;
    logic       branch;
    logic       reg_w;
    logic       mem_w;
    logic       ir_write;
    logic       adr_src;
    logic       alu_src_a;
    logic       alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
  } ctrl_t;

endpackage

// File: rtl/arm_multicycle_ctrl_if.sv
// Instruction fields and ALU flags in, datapath controls out.
interface arm_multicycle_ctrl_if;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] alu_flags;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_control;
  logic [1:0] imm_src;
  logic [1:0] reg_src;
  logic [3:0] state_o;

  modport master (
    input  cond, op, funct, rd, alu_flags,
    output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_control, imm_src, reg_src, state_o
  );

  modport slave (
    output cond, op, funct, rd, alu_flags,
    input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_control, imm_src, reg_src, state_o
  );
endinterface

// File: rtl/arm_multicycle_ctrl_cond.sv
// NZCV flags register, condition evaluation and the per-instruction
// condition-pass bit latched at the end of DECODE.
module arm_cond_unit
  import arm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic [1:0] flag_we_i,   // [1]=N,Z  [0]=C,V
  input  logic       latch_i,
  output logic       cond_ex_o
);
  logic [3:0] flags_q;
  logic       cond_ex_q;
  logic       n, z, c, v, cond_true;

  always_comb begin
    {n, z, c, v} = flags_q;
    case (cond_i)
      COND_EQ: cond_true = z;
      COND_NE: cond_true = ~z;
      COND_CS: cond_true = c;
      COND_CC: cond_true = ~c;
      COND_MI: cond_true = n;
      COND_PL: cond_true = ~n;
      COND_VS: cond_true = v;
      COND_VC: cond_true = ~v;
      COND_HI: cond_true = c & ~z;
      COND_LS: cond_true = ~c | z;
      COND_GE: cond_true = (n == v);
      COND_LT: cond_true = (n != v);
      COND_GT: cond_true = ~z & (n == v);
      COND_LE: cond_true = z | (n != v);
      default: cond_true = 1'b1;
    endcase
  end

  // Flag writes use the held pass bit, so a failed-condition instruction never touches NZCV.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      if (latch_i) cond_ex_q <= cond_true;
      if (flag_we_i[1] & cond_ex_q) flags_q[3:2] <= alu_flags_i[3:2];
      if (flag_we_i[0] & cond_ex_q) flags_q[1:0] <= alu_flags_i[1:0];
    end
  end

  assign cond_ex_o = cond_ex_q;
endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM control unit: main FSM, ALU decoder and condition-gated
// write enables. Outputs are combinational from state, funct and cond_ex.
module arm_multicycle_ctrl
  import arm_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  arm_multicycle_ctrl_if.master bus
);
  state_e     state_q, state_d;
  ctrl_t      ctl;
  logic [3:0] cmd;
  logic [1:0] alu_dec;
  logic       no_write, fl_nz, fl_cv, is_exec, cond_ex, pcs;

  assign cmd = bus.funct[4:1];

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE:
        case (bus.op)
          2'b00:   state_d = bus.funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      S_MEMADR:  state_d = bus.funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECR,
      S_EXECI:   state_d = S_ALUWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Command decode is kept independent of alu_op so ALUWB can still see no_write.
  always_comb begin
    alu_dec  = ALU_ADD;
    no_write = 1'b0;
    fl_nz    = 1'b0;
    fl_cv    = 1'b0;
    case (cmd)
      CMD_ADD: begin alu_dec = ALU_ADD; fl_nz = 1'b1; fl_cv = 1'b1; end
      CMD_SUB: begin alu_dec = ALU_SUB; fl_nz = 1'b1; fl_cv = 1'b1; end
      CMD_AND: begin alu_dec = ALU_AND; fl_nz = 1'b1; end
      CMD_ORR: begin alu_dec = ALU_ORR; fl_nz = 1'b1; end
      CMD_CMP: begin alu_dec = ALU_SUB; fl_nz = 1'b1; fl_cv = 1'b1; no_write = 1'b1; end
      default: no_write = 1'b1;
    endcase
  end

  always_comb begin
    ctl = '0;
    case (state_q)
      S_FETCH: begin
        ctl.ir_write   = 1'b1;
        ctl.next_pc    = 1'b1;
        ctl.alu_src_a  = 1'b1;
        ctl.alu_src_b  = SRCB_FOUR;
        ctl.result_src = RES_ALU;
      end
      S_DECODE: begin
        ctl.alu_src_a  = 1'b1;
        ctl.alu_src_b  = SRCB_FOUR;
        ctl.result_src = RES_ALU;
      end
      S_MEMADR:   ctl.alu_src_b = SRCB_IMM;
      S_MEMREAD:  ctl.adr_src = 1'b1;
      S_MEMWB: begin
        ctl.result_src = RES_DATA;
        ctl.reg_w      = 1'b1;
      end
      S_MEMWRITE: begin
        ctl.adr_src = 1'b1;
        ctl.mem_w   = 1'b1;
      end
      S_EXECR: begin
        ctl.alu_src_b = SRCB_REG;
        ctl.alu_op    = 1'b1;
      end
      S_EXECI: begin
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = 1'b1;
      end
      S_ALUWB:    ctl.reg_w = ~no_write;
      S_BRANCH: begin
        ctl.alu_src_b  = SRCB_IMM;
        ctl.result_src = RES_ALU;
        ctl.branch     = 1'b1;
      end
      default: ctl = '0;
    endcase
  end

  assign is_exec = (state_q == S_EXECR) | (state_q == S_EXECI);

  arm_cond_unit u_cond (
    .clk         (clk),
    .reset       (reset),
    .cond_i      (bus.cond),
    .alu_flags_i (bus.alu_flags),
    .flag_we_i   ({fl_nz, fl_cv} & {2{is_exec & bus.funct[0]}}),
    .latch_i     (state_q == S_DECODE),
    .cond_ex_o   (cond_ex)
  );

  assign pcs = ((bus.rd == 4'hF) & ctl.reg_w) | ctl.branch;

  // Write enables are squashed while reset is held so an aborted instruction leaves no trace.
  assign bus.pc_write    = ~reset & (ctl.next_pc | (pcs & cond_ex));
  assign bus.ir_write    = ~reset & ctl.ir_write;
  assign bus.reg_write   = ~reset & ctl.reg_w & cond_ex;
  assign bus.mem_write   = ~reset & ctl.mem_w & cond_ex;
  assign bus.adr_src     = ctl.adr_src;
  assign bus.result_src  = ctl.result_src;
  assign bus.alu_src_a   = ctl.alu_src_a;
  assign bus.alu_src_b   = ctl.alu_src_b;
  assign bus.alu_control = ctl.alu_op ? alu_dec : ALU_ADD;
  assign bus.imm_src     = bus.op;
  assign bus.reg_src     = {bus.op == 2'b01, bus.op == 2'b10};
  assign bus.state_o     = state_q;
endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Instruction-level reference model: each instruction expands into its expected
// per-cycle control trace, checked cycle by cycle against the controller.
module tb_arm_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_ins = 0;
  logic [3:0] flags_m;

  arm_multicycle_ctrl_if bus ();
  arm_multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] st;
    logic       pcw, irw, rw, mw, adr, asa;
    logic [1:0] rs, asb, ac;
    bit         exec;
  } rec_t;

  rec_t q[$];

  function automatic rec_t mk(input logic [3:0] st, input logic pcw, irw, rw, mw, adr,
                              input logic [1:0] rs, input logic asa,
                              input logic [1:0] asb, ac, input bit exec);
    rec_t r;
    r.st = st; r.pcw = pcw; r.irw = irw; r.rw = rw; r.mw = mw; r.adr = adr;
    r.rs = rs; r.asa = asa; r.asb = asb; r.ac = ac; r.exec = exec;
    return r;
  endfunction

  // ARM condition: even codes test a predicate, odd codes its negation; 111x always.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  // kind: 0 unsupported, 1 arithmetic, 2 logical, 3 compare
  function automatic void cmd_info(input logic [3:0] cmd, output int kind, output logic [1:0] ac);
    case (cmd)
      4'b0100: begin kind = 1; ac = 2'd0; end
      4'b0010: begin kind = 1; ac = 2'd1; end
      4'b0000: begin kind = 2; ac = 2'd2; end
      4'b1100: begin kind = 2; ac = 2'd3; end
      4'b1010: begin kind = 3; ac = 2'd1; end
      default: begin kind = 0; ac = 2'd0; end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s instr=%0d observed=%0h expected=%0h", tag, n_ins, obs, exp);
    end
  endtask

  task automatic check_cycle(input rec_t r, input bit rst, input logic [1:0] o);
    chk("state",       8'(bus.state_o),     8'(r.st));
    chk("pc_write",    8'(bus.pc_write),    8'(r.pcw & !rst));
    chk("ir_write",    8'(bus.ir_write),    8'(r.irw & !rst));
    chk("reg_write",   8'(bus.reg_write),   8'(r.rw & !rst));
    chk("mem_write",   8'(bus.mem_write),   8'(r.mw & !rst));
    chk("adr_src",     8'(bus.adr_src),     8'(r.adr));
    chk("result_src",  8'(bus.result_src),  8'(r.rs));
    chk("alu_src_a",   8'(bus.alu_src_a),   8'(r.asa));
    chk("alu_src_b",   8'(bus.alu_src_b),   8'(r.asb));
    chk("alu_control", 8'(bus.alu_control), 8'(r.ac));
    chk("imm_src",     8'(bus.imm_src),     8'(o));
    chk("reg_src",     8'(bus.reg_src),     8'({o == 2'b01, o == 2'b10}));
  endtask

  // Called at a negedge with the DUT in FETCH; returns at the negedge after the last cycle.
  task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] r, input logic [3:0] exec_af, input int abort_at);
    bit ce, wr;
    int kind;
    logic [1:0] ac;
    n_ins++;
    bus.cond = c; bus.op = o; bus.funct = f; bus.rd = r;
    ce = cond_ok(c, flags_m);
    cmd_info(f[4:1], kind, ac);
    q.delete();
    q.push_back(mk(4'd0, 1, 1, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 0));
    q.push_back(mk(4'd1, 0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 0));
    case (o)
      2'b01: begin
        q.push_back(mk(4'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 0));
        if (f[0]) begin
          q.push_back(mk(4'd3, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 0));
          q.push_back(mk(4'd4, ce && r == 4'hF, 0, ce, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0));
        end else
          q.push_back(mk(4'd5, 0, 0, 0, ce, 1, 2'b00, 0, 2'b00, 2'b00, 0));
      end
      2'b00: begin
        q.push_back(mk(f[5] ? 4'd7 : 4'd6, 0, 0, 0, 0, 0, 2'b00, 0,
                       f[5] ? 2'b01 : 2'b00, ac, 1));
        wr = ce && (kind == 1 || kind == 2);
        q.push_back(mk(4'd8, wr && r == 4'hF, 0, wr, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0));
      end
      2'b10: q.push_back(mk(4'd9, ce, 0, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00, 0));
      default: ;
    endcase
    foreach (q[i]) begin
      bus.alu_flags = q[i].exec ? exec_af : 4'($urandom);
      reset = (i == abort_at);
      #1;
      check_cycle(q[i], reset, o);
      if (reset) begin
        @(negedge clk);
        reset = 1'b0;
        flags_m = 4'b0000;
        return;
      end
      if (q[i].exec && f[0] && ce && kind != 0) begin
        if (kind == 2) flags_m[3:2] = bus.alu_flags[3:2];
        else           flags_m = bus.alu_flags;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    flags_m = 4'b0000;
    bus.cond = 4'hE; bus.op = 2'b00; bus.funct = 6'd0; bus.rd = 4'd0; bus.alu_flags = 4'd0;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rst_state", 8'(bus.state_o), 8'd0);
      chk("rst_we", 8'({bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write}), 8'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    run_instr(4'hE, 2'b00, 6'b101001, 4'd1,  4'b0100, -1); // ADDS R1
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0,  4'b0000, -1); // BEQ taken: Z=1 from ADDS
    run_instr(4'hE, 2'b00, 6'b010101, 4'd0,  4'b0100, -1); // CMP -> Z=1
    run_instr(4'h1, 2'b10, 6'b000000, 4'd0,  4'b0000, -1); // BNE not taken
    run_instr(4'hE, 2'b00, 6'b010101, 4'd0,  4'b0000, -1); // CMP -> Z=0
    run_instr(4'h1, 2'b10, 6'b000000, 4'd0,  4'b0000, -1); // BNE taken
    run_instr(4'hE, 2'b01, 6'b000001, 4'd2,  4'b0000, -1); // LDR
    run_instr(4'h0, 2'b01, 6'b000000, 4'd3,  4'b0000, -1); // STREQ, Z=0
    run_instr(4'hE, 2'b00, 6'b001000, 4'hF,  4'b0000, -1); // ADD PC
    run_instr(4'hE, 2'b11, 6'b000000, 4'd0,  4'b0000, -1); // op=11 no-op
    run_instr(4'hE, 2'b01, 6'b000000, 4'd4,  4'b0000, 2);  // STR aborted in MEMADR
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0,  4'b0000, -1); // BEQ after reset: flags cleared

    for (int k = 0; k < 400; k++) begin
      logic [3:0] c, r;
      logic [1:0] o;
      logic [5:0] f;
      c = 4'($urandom);
      o = 2'($urandom);
      f = 6'($urandom);
      if ($urandom_range(0, 2) == 0) f[4:1] = 4'b0100 + 4'($urandom_range(0, 1) * 8);
      r = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      run_instr(c, o, f, r, 4'($urandom), ($urandom_range(0, 30) == 0) ? 2 : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/arm_multicycle_ctrl.md
# arm_multicycle_ctrl

Control unit for the multicycle 32-bit ARM-like CPU. Sequences the shared datapath (PC, instruction, data and ALU-result registers; single memory; single ALU) through fetch/decode/execute/writeback states. Evaluates ARM condition codes against an internal NZCV flags register and gates every architectural write.

## Interface
No parameters; all widths are architectural.
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- cond  in  4  instr[31:28]
- op  in  2  instr[27:26]
- funct  in  6  instr[25:20]: I, cmd[3:0], S/L
- rd  in  4  instr[15:12]
- alu_flags  in  4  ALU NZCV, [3]=N … [0]=V
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address: 0=PC, 1=ALU result register
- mem_write  out  1  memory write enable
- ir_write  out  1  instruction register enable
- reg_write  out  1  register file write enable
- result_src  out  2  00=ALU result register, 01=data register, 10=ALU output
- alu_src_a  out  1  0=RD1 register, 1=PC
- alu_src_b  out  2  00=RD2 register, 01=extended immediate, 10=constant 4
- alu_control  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
- imm_src  out  2  equals op
- reg_src  out  2  [0]=(op==10), [1]=(op==01)
- state_o  out  4  current state, debug

## Operation
- States and transitions:
  - FETCH→DECODE
  - DECODE→MEMADR (op=01), EXECUTER (op=00, I=0), EXECUTEI (op=00, I=1), BRANCH (op=10), FETCH (op=11, no-op)
  - MEMADR→MEMREAD (L=1) / MEMWRITE (L=0)
  - MEMREAD→MEMWB
  - EXECUTER, EXECUTEI→ALUWB
  - MEMWB, MEMWRITE, ALUWB, BRANCH→FETCH
- Per-state controls (unlisted = 0/00):
  - FETCH: ir_write=1, next_pc=1, alu_src_a=1, alu_src_b=10, result_src=10, ADD
  - DECODE: alu_src_a=1, alu_src_b=10, result_src=10
  - MEMADR: alu_src_b=01, ADD
  - MEMREAD: adr_src=1
  - MEMWB: result_src=01, reg_w=1
  - MEMWRITE: adr_src=1, mem_w=1
  - EXECUTER: alu_src_b=00, alu_op=1
  - EXECUTEI: alu_src_b=01, alu_op=1
  - ALUWB: reg_w=1 unless no_write
  - BRANCH: alu_src_b=01, result_src=10, branch=1
- ALU decode when alu_op=1, by cmd:
  - ADD 0100→00; SUB 0010→01; AND 0000→10; ORR 1100→11
  - CMP 1010→01 with no_write=1
  - Any other cmd: 00, no_write=1, no flag write
- Gated outputs, using cond_ex_r:
  - reg_write = reg_w & cond_ex_r
  - mem_write = mem_w & cond_ex_r
  - pcs = (rd==15 & reg_w) | branch
  - pc_write = next_pc | (pcs & cond_ex_r)
- Condition evaluation:
  - EQ/NE: Z; CS/CC: C; MI/PL: N; VS/VC: V
  - HI: C&~Z; LS: ~C|Z
  - GE: N==V; LT: N!=V; GT: ~Z&(N==V); LE: Z|(N!=V)
  - AL (1110) and 1111: true
- cond_ex_r is latched at the end of DECODE from cond and the current flags, and held until the next DECODE.
- Flags update at the end of EXECUTER/EXECUTEI only when S=1, cond_ex_r=1 and cmd is supported:
  - ADD/SUB/CMP: all of NZCV
  - AND/ORR: N,Z only; C,V retained

## Timing
- Reset, sampled at posedge: state←FETCH, flags←0000, cond_ex_r←0.
- While reset=1: pc_write, ir_write, reg_write and mem_write are forced 0. All other outputs decode from state.
- First cycle after reset deasserts: FETCH with pc_write=1, ir_write=1.
- Cycles per instruction:
  - LDR: 5
  - STR: 4
  - Data-processing: 4
  - Branch: 3
  - op=11: 2
- Control outputs are combinational from state, funct and cond_ex_r; no output register.
- A flag write in EXECUTE is not visible to the same instruction's ALUWB gating; the next instruction's DECODE sees it.
- Reset asserted mid-instruction aborts it. No write enable fires in the reset cycle.

## Structure
- Package arm_ctrl_pkg holds:
  - 4-bit state encodings FETCH=0 … BRANCH=9
  - condition-code constants
  - cmd constants
  - alu_control, alu_src_b and result_src encodings
- Sub-module arm_cond_unit: NZCV register, condition evaluation and the cond_ex_r register. Inputs: cond, alu_flags, flag-write enables, latch strobe.
- The top level holds the main FSM and the ALU/instruction decoders.

## Test plan
- Reset: reset=1 for 2 cycles → state_o=0, all write enables 0; release → pc_write=1, ir_write=1 next cycle; flags=0000.
- ADDS R1 (cond=1110, op=00, funct=101001, alu_flags=0100) → states 0,1,7,8; reg_write=1 in ALUWB; flags=0100 afterwards.
- CMP then BNE:
  - CMP sets Z=1 (funct=010101, alu_flags=0100) → reg_write stays 0 in ALUWB.
  - BNE (cond=0001, op=10) → states 0,1,9; pc_write=0 in BRANCH.
  - Same with Z=0 → pc_write=1.
- LDR (op=01, funct[0]=1) → states 0,1,2,3,4; adr_src=1 in MEMREAD; result_src=01 and reg_write=1 in MEMWB.
- STR with cond=EQ and Z=0 → mem_write=0 in MEMWRITE.
- Data-processing with rd=15, AL → pc_write=1 in ALUWB.
- Reset asserted in MEMADR → next state FETCH, mem_write never asserted.
